// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: bundles the pipeline, MDU, issue/decode and regfile write-port signals of wb_arbiter.
// Port summary:
//   pipe_i_*   : in-order pipeline result (no backpressure), pipe_o_hold asks upstream for a bubble
//   mdu_i_*    : MDU result with valid/ready handshake, mdu_o_ready = result FIFO not full
//   issue_i_*  : MDU op issued by decode, marks its destination pending
//   decode_i_* : decode operands/destination checked against the pending bitmap, wb_o_stall on hit
//   write_back_o_* : registered regfile write port
// slave is the arbiter side, master the side that drives the arbiter.
interface wb_arbiter_if;
    logic        pipe_i_valid;
    logic        pipe_i_reg_wen;
    logic [4:0]  pipe_i_rd;
    logic [63:0] pipe_i_data;
    logic        pipe_o_hold;
    logic        mdu_i_valid;
    logic [4:0]  mdu_i_rd;
    logic [63:0] mdu_i_data;
    logic        mdu_o_ready;
    logic        issue_i_valid;
    logic [4:0]  issue_i_rd;
    logic [4:0]  decode_i_rs1;
    logic [4:0]  decode_i_rs2;
    logic [4:0]  decode_i_rd;
    logic        wb_o_stall;
    logic [4:0]  write_back_o_rd;
    logic [63:0] write_back_o_data;
    logic        write_back_o_reg_wen;

    modport slave (
        input  pipe_i_valid, pipe_i_reg_wen, pipe_i_rd, pipe_i_data,
        input  mdu_i_valid, mdu_i_rd, mdu_i_data,
        input  issue_i_valid, issue_i_rd,
        input  decode_i_rs1, decode_i_rs2, decode_i_rd,
        output pipe_o_hold, mdu_o_ready, wb_o_stall,
        output write_back_o_rd, write_back_o_data, write_back_o_reg_wen
    );

    modport master (
        output pipe_i_valid, pipe_i_reg_wen, pipe_i_rd, pipe_i_data,
        output mdu_i_valid, mdu_i_rd, mdu_i_data,
        output issue_i_valid, issue_i_rd,
        output decode_i_rs1, decode_i_rs2, decode_i_rd,
        input  pipe_o_hold, mdu_o_ready, wb_o_stall,
        input  write_back_o_rd, write_back_o_data, write_back_o_reg_wen
    );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges pipeline and MDU results onto the single regfile write port, tracks pending MDU destinations.
// Ports:
//   clk : clock, all state on posedge
//   rst : synchronous reset, active-low
//   bus : wb_arbiter_if.slave (pipeline, MDU, issue/decode and write-port signals)
module wb_arbiter #(
    parameter int MDU_FIFO_DEPTH = 2,
    parameter int STARVE_LIMIT   = 8
) (
    input logic          clk,
    input logic          rst,
    wb_arbiter_if.slave  bus
);
    localparam int AW = $clog2(MDU_FIFO_DEPTH);
    localparam int CW = $clog2(MDU_FIFO_DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]    fifo_rd_q   [MDU_FIFO_DEPTH];
    logic [63:0]   fifo_data_q [MDU_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          hold_q, hold_d;
    logic          src_mdu_q, src_mdu_d;
    logic          wen_q, wen_d;
    logic [4:0]    rd_q, rd_d;
    logic [63:0]   data_q, data_d;
    logic [31:0]   pending_q, pending_d;
    logic          slot_busy, empty, full, push, pop;
    logic [31:0]   set_mask, clr_mask;

    always_comb begin
        slot_busy = bus.pipe_i_valid && bus.pipe_i_reg_wen && bus.pipe_i_rd != 5'd0;
        empty     = count_q == '0;
        full      = count_q == CW'(MDU_FIFO_DEPTH);
        // rd==0 results are handshaken but never stored
        push      = bus.mdu_i_valid && !full && bus.mdu_i_rd != 5'd0;
        pop       = !slot_busy && !empty;
        // pointers wrap naturally because the depth is a power of two
        wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d   = count_q + CW'(push) - CW'(pop);
        wen_d     = slot_busy || pop;
        src_mdu_d = pop;
        rd_d      = slot_busy ? bus.pipe_i_rd : pop ? fifo_rd_q[rd_ptr_q] : rd_q;
        data_d    = slot_busy ? bus.pipe_i_data : pop ? fifo_data_q[rd_ptr_q] : data_q;
        starve_d  = (pop || empty) ? '0 : (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + SW'(1);
        hold_d    = starve_d == SW'(STARVE_LIMIT);
        // the clear lands on the same edge the regfile commits the MDU result
        clr_mask  = (wen_q && src_mdu_q) ? 32'd1 << rd_q : 32'd0;
        set_mask  = (bus.issue_i_valid && bus.issue_i_rd != 5'd0) ? 32'd1 << bus.issue_i_rd : 32'd0;
        pending_d = (pending_q & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q]   <= bus.mdu_i_rd;
            fifo_data_q[wr_ptr_q] <= bus.mdu_i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            starve_q  <= '0;
            hold_q    <= 1'b0;
            src_mdu_q <= 1'b0;
            wen_q     <= 1'b0;
            rd_q      <= '0;
            data_q    <= '0;
            pending_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            starve_q  <= starve_d;
            hold_q    <= hold_d;
            src_mdu_q <= src_mdu_d;
            wen_q     <= wen_d;
            rd_q      <= rd_d;
            data_q    <= data_d;
            pending_q <= pending_d;
        end
    end

    assign bus.mdu_o_ready          = !full;
    assign bus.pipe_o_hold          = hold_q;
    assign bus.write_back_o_reg_wen = wen_q;
    assign bus.write_back_o_rd      = rd_q;
    assign bus.write_back_o_data    = data_q;
    assign bus.wb_o_stall           = (bus.decode_i_rs1 != 5'd0 && pending_q[bus.decode_i_rs1]) ||
                                      (bus.decode_i_rs2 != 5'd0 && pending_q[bus.decode_i_rs2]) ||
                                      (bus.decode_i_rd  != 5'd0 && pending_q[bus.decode_i_rd]);
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed stimulus with queued expectations checked by a negedge monitor.
module tb_wb_arbiter;
    localparam int READY = 0, STALL = 1, HOLD = 2, WEN = 3;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
        int          at;
    } wr_t;

    typedef struct {
        int   sig;
        logic val;
    } st_t;

    logic  clk = 1'b0;
    logic  rst;
    int    cyc = 0;
    bit    done = 1'b0;
    int    n_cmp = 0;
    int    n_bad = 0;
    wr_t   wq[$];
    st_t   sq[$];
    string nm [4] = '{"mdu_o_ready", "wb_o_stall", "pipe_o_hold", "write_back_o_reg_wen"};

    wb_arbiter_if bus();

    wb_arbiter #(.MDU_FIFO_DEPTH(2), .STARVE_LIMIT(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic sig_val(int s);
        return s == READY ? bus.mdu_o_ready : s == STALL ? bus.wb_o_stall :
               s == HOLD ? bus.pipe_o_hold : bus.write_back_o_reg_wen;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_st(int s, logic v);
        st_t e;
        e.sig = s;
        e.val = v;
        sq.push_back(e);
    endtask

    task automatic exp_wr(logic [4:0] rd, logic [63:0] data, int lat);
        wr_t e;
        e.rd = rd;
        e.data = data;
        e.at = cyc + lat;
        wq.push_back(e);
    endtask

    task automatic pipe_w(logic [4:0] rd, logic [63:0] data);
        bus.pipe_i_valid = 1'b1;
        bus.pipe_i_reg_wen = 1'b1;
        bus.pipe_i_rd = rd;
        bus.pipe_i_data = data;
        exp_wr(rd, data, 1);
    endtask

    task automatic mdu(logic v, logic [4:0] rd, logic [63:0] data);
        bus.mdu_i_valid = v;
        bus.mdu_i_rd = rd;
        bus.mdu_i_data = data;
    endtask

    // monitor: sole owner of the comparison counters
    initial begin
        st_t s;
        wr_t w;
        logic a;
        forever begin
            @(negedge clk);
            while (sq.size() > 0) begin
                s = sq.pop_front();
                a = sig_val(s.sig);
                n_cmp++;
                if (a !== s.val) begin
                    n_bad++;
                    $display("FAIL %s @cycle %0d: got %b want %b", nm[s.sig], cyc, a, s.val);
                end
            end
            if (bus.write_back_o_reg_wen === 1'b1) begin
                n_cmp++;
                if (wq.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_write @cycle %0d: got rd=%0d data=%h want no write",
                             cyc, bus.write_back_o_rd, bus.write_back_o_data);
                end else begin
                    w = wq.pop_front();
                    if (bus.write_back_o_rd !== w.rd || bus.write_back_o_data !== w.data || cyc != w.at) begin
                        n_bad++;
                        $display("FAIL write_port: got rd=%0d data=%h cycle=%0d want rd=%0d data=%h cycle=%0d",
                                 bus.write_back_o_rd, bus.write_back_o_data, cyc, w.rd, w.data, w.at);
                    end
                end
            end
            if (done || cyc > 1000) begin
                n_cmp++;
                if (!done || wq.size() != 0) begin
                    n_bad++;
                    $display("FAIL end_of_run: got done=%0b pending_writes=%0d want done=1 pending_writes=0",
                             done, wq.size());
                end
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
                $finish;
            end
        end
    end

    initial begin
        rst = 1'b0;
        bus.pipe_i_valid = 1'b0;
        bus.pipe_i_reg_wen = 1'b0;
        bus.pipe_i_rd = '0;
        bus.pipe_i_data = '0;
        mdu(1'b0, 5'd0, 64'd0);
        bus.issue_i_valid = 1'b0;
        bus.issue_i_rd = '0;
        bus.decode_i_rs1 = '0;
        bus.decode_i_rs2 = '0;
        bus.decode_i_rd = '0;
        tick();
        tick();
        rst = 1'b1;
        exp_st(READY, 1'b1);
        exp_st(STALL, 1'b0);
        exp_st(HOLD, 1'b0);
        exp_st(WEN, 1'b0);
        tick();
        // pipeline-only writes; rd==0 and reg_wen==0 must not write
        pipe_w(5'd5, 64'hDEAD);
        tick();
        bus.pipe_i_rd = 5'd0;
        tick();
        exp_st(WEN, 1'b0);
        bus.pipe_i_rd = 5'd5;
        bus.pipe_i_reg_wen = 1'b0;
        tick();
        exp_st(WEN, 1'b0);
        bus.pipe_i_valid = 1'b0;
        mdu(1'b1, 5'd0, 64'hBAD);
        exp_st(READY, 1'b1);
        tick();
        mdu(1'b0, 5'd0, 64'd0);
        tick();
        exp_st(WEN, 1'b0);
        exp_st(READY, 1'b1);
        tick();
        // MDU-only path with scoreboard
        bus.issue_i_valid = 1'b1;
        bus.issue_i_rd = 5'd7;
        tick();
        bus.issue_i_valid = 1'b0;
        bus.decode_i_rs1 = 5'd7;
        exp_st(STALL, 1'b1);
        mdu(1'b1, 5'd7, 64'h1234);
        exp_st(READY, 1'b1);
        exp_wr(5'd7, 64'h1234, 2);
        tick();
        mdu(1'b0, 5'd0, 64'd0);
        exp_st(STALL, 1'b1);
        tick();
        exp_st(STALL, 1'b1);
        tick();
        exp_st(STALL, 1'b0);
        tick();
        bus.decode_i_rs1 = 5'd0;
        bus.issue_i_valid = 1'b1;
        bus.issue_i_rd = 5'd12;
        tick();
        bus.issue_i_valid = 1'b0;
        bus.decode_i_rs2 = 5'd12;
        exp_st(STALL, 1'b1);
        tick();
        bus.decode_i_rs2 = 5'd0;
        bus.decode_i_rd = 5'd12;
        exp_st(STALL, 1'b1);
        tick();
        bus.decode_i_rd = 5'd0;
        exp_st(STALL, 1'b0);
        tick();
        // collision: FIFO fills behind a busy pipe, third result held off
        pipe_w(5'd10, 64'h100);
        mdu(1'b1, 5'd3, 64'h33);
        exp_st(READY, 1'b1);
        tick();
        pipe_w(5'd11, 64'h101);
        mdu(1'b1, 5'd4, 64'h44);
        exp_st(READY, 1'b1);
        tick();
        pipe_w(5'd12, 64'h102);
        mdu(1'b1, 5'd6, 64'h66);
        exp_st(READY, 1'b0);
        tick();
        pipe_w(5'd13, 64'h103);
        exp_st(READY, 1'b0);
        tick();
        bus.pipe_i_valid = 1'b0;
        mdu(1'b0, 5'd0, 64'd0);
        exp_st(READY, 1'b0);
        exp_wr(5'd3, 64'h33, 1);
        tick();
        exp_st(READY, 1'b1);
        exp_wr(5'd4, 64'h44, 1);
        tick();
        exp_st(READY, 1'b1);
        tick();
        // starvation: one entry denied for 8 busy cycles, pipe still wins while hold=1
        for (int i = 0; i < 10; i++) begin
            pipe_w(5'd14, 64'h200 + 64'(i));
            if (i == 0) mdu(1'b1, 5'd20, 64'h2020);
            else mdu(1'b0, 5'd0, 64'd0);
            exp_st(HOLD, logic'(i >= 9));
            tick();
        end
        bus.pipe_i_valid = 1'b0;
        exp_st(HOLD, 1'b1);
        exp_wr(5'd20, 64'h2020, 1);
        tick();
        exp_st(HOLD, 1'b0);
        tick();
        // same-edge clear and set on rd=9: set wins
        bus.issue_i_valid = 1'b1;
        bus.issue_i_rd = 5'd9;
        tick();
        bus.issue_i_valid = 1'b0;
        mdu(1'b1, 5'd9, 64'h99);
        exp_wr(5'd9, 64'h99, 2);
        tick();
        mdu(1'b0, 5'd0, 64'd0);
        tick();
        bus.issue_i_valid = 1'b1;
        bus.issue_i_rd = 5'd9;
        tick();
        bus.issue_i_valid = 1'b0;
        bus.decode_i_rs1 = 5'd9;
        exp_st(STALL, 1'b1);
        tick();
        exp_st(STALL, 1'b1);
        tick();
        // reset with two buffered results and pending bits
        pipe_w(5'd15, 64'h300);
        mdu(1'b1, 5'd21, 64'h2121);
        exp_st(STALL, 1'b1);
        tick();
        pipe_w(5'd16, 64'h301);
        mdu(1'b1, 5'd22, 64'h2222);
        tick();
        bus.pipe_i_valid = 1'b0;
        mdu(1'b0, 5'd0, 64'd0);
        exp_st(READY, 1'b0);
        rst = 1'b0;
        tick();
        exp_st(WEN, 1'b0);
        exp_st(READY, 1'b1);
        tick();
        rst = 1'b1;
        bus.decode_i_rs2 = 5'd12;
        bus.decode_i_rd = 5'd7;
        exp_st(STALL, 1'b0);
        exp_st(HOLD, 1'b0);
        exp_st(READY, 1'b1);
        exp_st(WEN, 1'b0);
        tick();
        exp_st(WEN, 1'b0);
        tick();
        exp_st(WEN, 1'b0);
        tick();
        done = 1'b1;
    end
endmodule
